// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial feeder for the serial pattern-detect FSM. Words are
//   accepted through a valid/ready handshake and shifted out one bit per
//   bit_en strobe on the serial line `a`. A word can be accepted on the
//   cycle its predecessor's last bit is consumed, so consecutive words
//   stream with no idle gap.
//
// Parameters
//   WIDTH     parallel word width (>= 2)
//   MSB_FIRST 1: shift MSB first, 0: shift LSB first
//   IDLE_BIT  level driven on `a` while no word is in flight
//
// Ports
//   clk        system clock, all flops on posedge
//   reset      asynchronous active-high reset
//   din        parallel word to serialize
//   din_valid  din holds a word to transfer
//   din_ready  block can accept a word this cycle (combinational)
//   bit_en     bit-advance strobe, tie high for one bit per clk
//   a          serial bit to the downstream detector
//   a_valid    a carries a data bit rather than idle fill
//   busy       a word is in flight
//   done       one-cycle pulse after the last bit of a word is consumed
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // One-hot encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_SHIFT = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic             last_bit;
    logic             xfer;
    logic             head;

    // Move the next bit into the head position (MSB or LSB end).
    function automatic logic [WIDTH-1:0] shift_head(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    always_comb begin
        // The last bit is consumed at this edge; the slot is free for a new word.
        last_bit  = (state == ST_SHIFT) && (cnt == LAST) && bit_en;
        din_ready = (state == ST_IDLE) || last_bit;
        xfer      = din_valid && din_ready;

        state_nxt = ST_IDLE;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        done_nxt  = last_bit;

        unique case (state)
            ST_IDLE: begin
                if (xfer) begin
                    sreg_nxt  = din;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                state_nxt = ST_SHIFT;
                if (bit_en) begin
                    if (cnt == LAST) begin
                        if (xfer) begin
                            sreg_nxt = din;
                            cnt_nxt  = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        sreg_nxt = shift_head(sreg);
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // Outputs decode only from flops, so din/din_valid never reach `a` combinationally.
    assign head    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign busy    = (state == ST_SHIFT);
    assign a_valid = busy;
    assign a       = busy ? head : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       bit_en;
    logic       a0;
    logic       a0_valid;
    logic       busy;
    logic       done;

    logic [7:0] din1;
    logic       din1_valid;
    logic       din1_ready;
    logic       bit_en1;
    logic       a1;
    logic       a1_valid;
    logic       busy1;
    logic       done1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done1_cnt = 0;

    bit q0[$];
    bit q1[$];
    int exp_done[$];
    bit e0;
    bit e1;
    int ed;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .bit_en(bit_en), .a(a0), .a_valid(a0_valid),
        .busy(busy), .done(done)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
        .clk(clk), .reset(reset), .din(din1), .din_valid(din1_valid),
        .din_ready(din1_ready), .bit_en(bit_en1), .a(a1), .a_valid(a1_valid),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the MSB-first instance: a bit is consumed on
    // an edge where a_valid and bit_en are both high.
    always @(negedge clk) begin
        if (!reset) begin
            if (a0_valid && bit_en) begin
                if (q0.size() == 0) begin
                    chk("u0_unexpected_bit", 1, 0);
                end else begin
                    e0 = q0.pop_front();
                    chk("u0_bit", int'(a0), int'(e0));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("u0_unexpected_done", 1, 0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("u0_done_cycle", cyc, ed);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (a1_valid && bit_en1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_bit", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk("u1_bit", int'(a1), int'(e1));
                end
            end
            if (done1) done1_cnt++;
        end
    end

    task automatic push0(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q0.push_back(w[i]);
    endtask

    task automatic push1(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q1.push_back(w[i]);
    endtask

    // Present w to u0 and wait (bounded) for the transfer edge; k is its cycle.
    task automatic xfer(input logic [7:0] w, output int k);
        din = w;
        din_valid = 1'b1;
        k = -1;
        for (int n = 0; n < 50; n++) begin
            if (din_ready) begin
                @(posedge clk);
                #1;
                k = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (k < 0) chk("u0_xfer_timeout", 0, 1);
    endtask

    task automatic xfer1(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        din1 = w;
        din1_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (din1_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        din1_valid = 1'b0;
        if (!ok) chk("u1_xfer_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int k2;
        reset = 1'b1;
        din = '0; din_valid = 1'b0; bit_en = 1'b1;
        din1 = '0; din1_valid = 1'b0; bit_en1 = 1'b1;
        #1;
        chk("rst_a", int'(a0), 0);
        chk("rst_a_valid", int'(a0_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_din_ready", int'(din_ready), 1);
        chk("rst_a1_idle", int'(a1), 1);
        idle(2);
        reset = 1'b0;
        idle(2);

        // Single word, MSB first
        xfer(8'hB4, k);
        push0(8'hB4);
        exp_done.push_back(k + 8);
        idle(10);
        chk("single_idle_a", int'(a0), 0);
        chk("single_idle_a_valid", int'(a0_valid), 0);
        chk("single_idle_ready", int'(din_ready), 1);

        // Back-to-back words, second accepted on the last-bit cycle
        xfer(8'hB4, k);
        push0(8'hB4);
        exp_done.push_back(k + 8);
        xfer(8'h0F, k2);
        push0(8'h0F);
        exp_done.push_back(k2 + 8);
        chk("b2b_accept_cycle", k2, k + 8);
        chk("b2b_a_valid", int'(a0_valid), 1);
        idle(12);

        // Rate strobe: each bit held two cycles
        xfer(8'hC3, k);
        push0(8'hC3);
        exp_done.push_back(k + 16);
        for (int i = 0; i < 16; i++) begin
            bit_en = (i % 2 == 1);
            #1;
            chk("strobe_ready", int'(din_ready), (i == 15) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        idle(4);

        // Busy hold: a word offered during the 3rd bit waits for the last-bit cycle
        xfer(8'hB4, k);
        push0(8'hB4);
        exp_done.push_back(k + 8);
        idle(2);
        din = 8'hFF;
        din_valid = 1'b1;
        #1;
        chk("hold_not_ready", int'(din_ready), 0);
        xfer(8'hFF, k2);
        push0(8'hFF);
        exp_done.push_back(k2 + 8);
        chk("hold_accept_cycle", k2, k + 8);
        idle(12);

        // Reset mid-word discards the partial word
        xfer(8'hB4, k);
        push0(8'hB4);
        exp_done.push_back(k + 8);
        idle(3);
        reset = 1'b1;
        q0.delete();
        exp_done.delete();
        #1;
        chk("midrst_a", int'(a0), 0);
        chk("midrst_a_valid", int'(a0_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(din_ready), 1);
        idle(1);
        reset = 1'b0;
        idle(12);
        xfer(8'h0F, k);
        push0(8'h0F);
        exp_done.push_back(k + 8);
        idle(12);

        // LSB-first instance with idle level 1
        xfer1(8'hB4);
        push1(8'hB4);
        chk("u1_busy", int'(busy1), 1);
        idle(12);
        chk("u1_idle_a", int'(a1), 1);
        chk("u1_idle_a_valid", int'(a1_valid), 0);
        chk("u1_done_count", done1_cnt, 1);

        chk("u0_bits_left", q0.size(), 0);
        chk("u0_done_left", exp_done.size(), 0);
        chk("u1_bits_left", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
